// File: rtl/tdc_spi_cfg_slave.sv
// SPI responder for TDC configuration frames: oversamples csb/sclk/din on clk,
// deserializes MSB-first words and files consecutive frames into five registers.
module tdc_spi_cfg_slave #(
   parameter int FRAME_BITS = 24,
   parameter int NUM_REGS   = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  csb,
   input  logic                  sclk,
   input  logic                  din,
   output logic [FRAME_BITS-1:0] reg_config,
   output logic [FRAME_BITS-1:0] reg_coarseovf,
   output logic [FRAME_BITS-1:0] reg_clkctrovf,
   output logic [FRAME_BITS-1:0] reg_clkstopmask,
   output logic [FRAME_BITS-1:0] reg_interrupts,
   output logic                  word_valid,
   output logic [2:0]            word_idx,
   output logic                  cfg_done,
   output logic                  frame_err,
   output logic [2:0]            dbg_state
);

   // Handshake: none on the SPI side; word_valid/cfg_done/frame_err are
   // single-cycle strobes with no back-pressure, word_idx qualified by word_valid.

   typedef enum logic [2:0] {
      IDX0 = 3'd0,
      IDX1 = 3'd1,
      IDX2 = 3'd2,
      IDX3 = 3'd3,
      IDX4 = 3'd4
   } idx_e;

   localparam logic [4:0] FB = 5'(FRAME_BITS);

   logic csb_s1_q, csb_s2_q, csb_s3_q;
   logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
   logic din_s1_q, din_s2_q;

   logic [FRAME_BITS-1:0] shift_q, shift_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [FRAME_BITS-1:0] regs_q [NUM_REGS];
   idx_e                  state_q;

   logic csb_fall, csb_rise, sclk_rise, frame_ok;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csb_s1_q  <= 1'b1;
         csb_s2_q  <= 1'b1;
         csb_s3_q  <= 1'b1;
         sclk_s1_q <= 1'b0;
         sclk_s2_q <= 1'b0;
         sclk_s3_q <= 1'b0;
         din_s1_q  <= 1'b0;
         din_s2_q  <= 1'b0;
      end else begin
         csb_s1_q  <= csb;
         csb_s2_q  <= csb_s1_q;
         csb_s3_q  <= csb_s2_q;
         sclk_s1_q <= sclk;
         sclk_s2_q <= sclk_s1_q;
         sclk_s3_q <= sclk_s2_q;
         din_s1_q  <= din;
         din_s2_q  <= din_s1_q;
      end
   end

   assign csb_fall  = !csb_s2_q && csb_s3_q;
   assign csb_rise  = csb_s2_q && !csb_s3_q;
   assign sclk_rise = sclk_s2_q && !sclk_s3_q;
   assign frame_ok  = (cnt_q >= FB);

   // Counter keeps running past FRAME_BITS so a padded frame still closes cleanly.
   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (csb_fall) begin
         shift_d = '0;
         cnt_d   = '0;
      end else if (sclk_rise && !csb_s2_q && !csb_rise) begin
         if (cnt_q < FB) shift_d = {shift_q[FRAME_BITS-2:0], din_s2_q};
         if (cnt_q != 5'd31) cnt_d = cnt_q + 5'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDX0;
         word_valid <= 1'b0;
         word_idx   <= 3'd0;
         cfg_done   <= 1'b0;
         frame_err  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         word_valid <= 1'b0;
         cfg_done   <= 1'b0;
         frame_err  <= 1'b0;
         if (state_q > IDX4) begin
            state_q <= IDX0;
         end else if (csb_rise) begin
            if (!frame_ok) begin
               frame_err <= 1'b1;
            end else begin
               word_valid <= 1'b1;
               word_idx   <= state_q;
               case (state_q)
                  IDX0: begin regs_q[0] <= shift_q; state_q <= IDX1; end
                  IDX1: begin regs_q[1] <= shift_q; state_q <= IDX2; end
                  IDX2: begin regs_q[2] <= shift_q; state_q <= IDX3; end
                  IDX3: begin regs_q[3] <= shift_q; state_q <= IDX4; end
                  IDX4: begin
                     regs_q[4] <= shift_q;
                     state_q   <= IDX0;
                     cfg_done  <= 1'b1;
                  end
                  default: state_q <= IDX0;
               endcase
            end
         end
      end
   end

   assign reg_config      = regs_q[0];
   assign reg_coarseovf   = regs_q[1];
   assign reg_clkctrovf   = regs_q[2];
   assign reg_clkstopmask = regs_q[3];
   assign reg_interrupts  = regs_q[4];
   assign dbg_state       = state_q;

endmodule

// File: tb/tb_tdc_spi_cfg_slave.sv
// Bench for tdc_spi_cfg_slave: drives SPI frames with random data and phase,
// predicts register writes and strobes from a frame-level model.
module tb_tdc_spi_cfg_slave;

   localparam int W = 30;

   logic        clk, rst, csb, sclk, din;
   logic [23:0] reg_config, reg_coarseovf, reg_clkctrovf, reg_clkstopmask, reg_interrupts;
   logic        word_valid, cfg_done, frame_err;
   logic [2:0]  word_idx, dbg_state;

   tdc_spi_cfg_slave dut (
      .clk             (clk),
      .rst             (rst),
      .csb             (csb),
      .sclk            (sclk),
      .din             (din),
      .reg_config      (reg_config),
      .reg_coarseovf   (reg_coarseovf),
      .reg_clkctrovf   (reg_clkctrovf),
      .reg_clkstopmask (reg_clkstopmask),
      .reg_interrupts  (reg_interrupts),
      .word_valid      (word_valid),
      .word_idx        (word_idx),
      .cfg_done        (cfg_done),
      .frame_err       (frame_err),
      .dbg_state       (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
      else n_pass++;
   endtask

   // reference model: frame index, last written index, register image
   logic [W-1:0] exp_q[$];
   logic [23:0]  m_regs [5];
   int           m_idx, m_last;

   task automatic model_reset();
      for (int i = 0; i < 5; i++) m_regs[i] = '0;
      m_idx  = 0;
      m_last = 0;
      exp_q.delete();
   endtask

   function automatic logic [23:0] reg_at(input logic [2:0] idx);
      case (idx)
         3'd0: return reg_config;
         3'd1: return reg_coarseovf;
         3'd2: return reg_clkctrovf;
         3'd3: return reg_clkstopmask;
         3'd4: return reg_interrupts;
         default: return 24'hDEAD00;
      endcase
   endfunction

   // scoreboard: every strobe must match the oldest predicted event
   always @(negedge clk) begin
      logic [W-1:0] obs;
      if (!rst && (word_valid || frame_err || cfg_done)) begin
         obs = {cfg_done, frame_err, word_valid, word_idx,
                frame_err ? 24'h0 : reg_at(word_idx)};
         if (exp_q.size() == 0) chk("unexpected_evt", 32'(obs), 32'd0);
         else chk("event", 32'(obs), 32'(exp_q.pop_front()));
      end
   end

   // driver tasks; all SPI edges land on multiples of 10 ns after a random offset
   task automatic align();
      @(posedge clk);
      #($urandom_range(1, 9));
   endtask

   task automatic open_bits(input logic [23:0] word, input int nbits, input int half);
      csb = 1'b0;
      #(half);
      for (int i = 0; i < nbits; i++) begin
         if (i < 24) din = word[23-i];
         else if (i == 24) din = 1'b0;
         else din = 1'($urandom_range(0, 1));
         #(half);
         sclk = 1'b1;
         #(half);
         sclk = 1'b0;
      end
   endtask

   task automatic close_frame(input int half);
      #(half);
      csb = 1'b1;
      din = 1'b0;
      #(40);
   endtask

   task automatic send(input logic [23:0] word, input int nbits, input int half);
      if (nbits >= 24) begin
         exp_q.push_back({(m_idx == 4), 1'b0, 1'b1, 3'(m_idx), word});
         m_regs[m_idx] = word;
         m_last = m_idx;
         m_idx = (m_idx + 1) % 5;
      end else begin
         exp_q.push_back({3'b010, 3'(m_last), 24'h0});
      end
      open_bits(word, nbits, half);
      close_frame(half);
   endtask

   function automatic int rand_half();
      return 10 * $urandom_range(2, 4);
   endfunction

   task automatic drain_and_check(input string tag);
      repeat (12) @(posedge clk);
      #1;
      chk({tag, "_drain"}, exp_q.size(), 0);
      chk({tag, "_state"}, 32'(dbg_state), 32'(m_idx));
      chk({tag, "_config"}, reg_config, m_regs[0]);
      chk({tag, "_coarseovf"}, reg_coarseovf, m_regs[1]);
      chk({tag, "_clkctrovf"}, reg_clkctrovf, m_regs[2]);
      chk({tag, "_clkstopmask"}, reg_clkstopmask, m_regs[3]);
      chk({tag, "_interrupts"}, reg_interrupts, m_regs[4]);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_config"}, reg_config, 0);
      chk({tag, "_coarseovf"}, reg_coarseovf, 0);
      chk({tag, "_clkctrovf"}, reg_clkctrovf, 0);
      chk({tag, "_clkstopmask"}, reg_clkstopmask, 0);
      chk({tag, "_interrupts"}, reg_interrupts, 0);
      chk({tag, "_strobes"}, {word_valid, cfg_done, frame_err}, 0);
      chk({tag, "_word_idx"}, 32'(word_idx), 0);
      chk({tag, "_state"}, 32'(dbg_state), 0);
   endtask

   logic [23:0] full_seq [5];

   initial begin
      full_seq[0] = 24'hA5A5A5;
      full_seq[1] = 24'h000123;
      full_seq[2] = 24'h00FFFF;
      full_seq[3] = 24'h800001;
      full_seq[4] = 24'h7FFFFE;
      model_reset();
      rst = 1'b1; csb = 1'b1; sclk = 1'b0; din = 1'b0;
      #17;
      check_all_zero("reset_held");
      #10;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset_released");

      // full sequence, plain 24-bit frames
      align();
      for (int i = 0; i < 5; i++) send(full_seq[i], 24, rand_half());
      drain_and_check("full_seq");

      // padded frames: 25th bit zero, plus a long frame that saturates the counter
      align();
      for (int i = 0; i < 5; i++) send(24'($urandom), 25, rand_half());
      send(24'($urandom), 34, 20);
      drain_and_check("padded");

      // short frame, empty frame, then fill the rest of the sequence
      align();
      model_reset();
      rst = 1'b1; #20; rst = 1'b0; #20;
      send(24'($urandom), 24, rand_half());
      send(24'hFFFFFF, 23, rand_half());
      send(24'h000042, 24, rand_half());
      send(24'h0, 0, 20);
      for (int i = 0; i < 3; i++) send(24'($urandom), 24, rand_half());
      drain_and_check("short");

      // wrap-around: ten consecutive frames, mixed lengths
      align();
      for (int i = 0; i < 10; i++)
         send(24'($urandom), $urandom_range(24, 26), rand_half());
      drain_and_check("wrap");

      // reset in the middle of frame 2
      align();
      send(24'($urandom), 24, rand_half());
      send(24'($urandom), 24, rand_half());
      repeat (4) @(posedge clk);
      #1;
      open_bits(24'($urandom), 12, 20);
      #(10);
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      model_reset();
      csb = 1'b1; sclk = 1'b0; din = 1'b0;
      #30;
      rst = 1'b0;
      align();
      send(24'h123456, 24, rand_half());
      drain_and_check("after_reset");

      // fastest legal sclk with a fresh random phase per frame
      for (int i = 0; i < 5; i++) begin
         align();
         send(24'($urandom), 24, 20);
      end
      drain_and_check("margin");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #3000000;
      chk("global_timeout", 1, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tdc_spi_cfg_slave.md
# tdc_spi_cfg_slave

SPI responder that receives the TDC configuration frames sent by the TDC configuration master. It deserializes MSB-first 24-bit words delimited by `csb` and stores consecutive frames into five configuration registers: config, coarseovf, clkctrovf, clkstopmask and interrupts. It sits on the emulator/test FPGA side of the link, standing in for the TDC, and flags completion and framing errors to local logic. SPI inputs are asynchronous to `clk` and are oversampled.

## Interface
Parameters:
- FRAME_BITS, 24, data bits per frame; also the width of each register
- NUM_REGS, 5, frames per configuration sequence (fixed register map below)

Ports:
- clk  input  1  system clock; the only clock; samples the SPI lines
- rst  input  1  reset, asynchronous, active-high; all state and outputs cleared immediately
- csb  input  1  SPI chip select, active-low, asynchronous to clk
- sclk  input  1  SPI clock, asynchronous; data valid on its rising edge
- din  input  1  SPI serial data from master, MSB first
- reg_config  output  24  frame 0 contents
- reg_coarseovf  output  24  frame 1 contents
- reg_clkctrovf  output  24  frame 2 contents
- reg_clkstopmask  output  24  frame 3 contents
- reg_interrupts  output  24  frame 4 contents
- word_valid  output  1  1-clk pulse: a register was just written
- word_idx  output  3  index (0..4) of the register written; valid with word_valid
- cfg_done  output  1  1-clk pulse, coincident with word_valid for index 4
- frame_err  output  1  1-clk pulse: frame closed with fewer than FRAME_BITS bits

## Operation
- `csb`, `sclk` and `din` each pass through a 2-FF synchronizer (s1, s2). One history flop (s3) on `csb` and `sclk` supports edge detection.
- Frame start: a `csb` falling edge (s2=0, s3=1) clears the shift register and the 5-bit bit counter.
- Bit capture: a `sclk` rising edge while synchronized `csb`=0 and no `csb` rising edge is in the same cycle:
  - If count < FRAME_BITS, the shift register takes `{shift[22:0], din_s2}`.
  - The counter increments and saturates at 31.
  - Bits beyond FRAME_BITS are ignored; frames with FRAME_BITS+1 bits (trailing pad) are accepted.
- Frame end (`csb` rising edge):
  - count ≥ FRAME_BITS: the shift register is written to the register selected by the frame index, `word_valid` pulses, and `word_idx` = index.
    - If index = NUM_REGS-1, `cfg_done` pulses and the index wraps to 0.
    - Otherwise the index increments.
  - count < FRAME_BITS (including 0): `frame_err` pulses. No register is written and the index is unchanged.
- Frame index FSM states: IDX0..IDX4 (encoded 0..4), advancing only on accepted frames.
  - Codes 5..7 are unreachable. If entered, the next state is IDX0.
- A `csb` rising edge with no preceding falling edge since reset is treated as a 0-bit frame and produces `frame_err`.
- The block does not drive any SPI line.

## Timing
- Reset values: all five registers 0, index 0, `word_valid` 0, `word_idx` 0, `cfg_done` 0, `frame_err` 0, shift register 0, counter 0. Synchronizer flops reset to `csb`=1, `sclk`=0, `din`=0.
- Latency: a pad transition first captured by s1 at clk edge k is acted on at edge k+2. Registers and pulses are visible after edge k+2.
- Pulses last exactly one clk. `word_idx` holds its last value between pulses.
- Input constraints:
  - `sclk` high and low phases each ≥ 2 clk periods (f_sclk ≤ f_clk/4).
  - `csb` high between frames ≥ 2 clk periods.
  - `din` stable ≥ 2 clk before and after the `sclk` rising edge.
- Reset mid-frame discards the partial word. The next frame is treated as frame 0.

## Test plan
- Full sequence: 5 frames with data 0xA5A5A5, 0x000123, 0x00FFFF, 0x800001, 0x7FFFFE, 24 bits each → registers hold these values; `word_idx` pulses 0..4; `cfg_done` pulses once, with the index-4 `word_valid`.
- Padded frames: 25 sclk edges per frame, 25th bit = 0 → same register values as 24-bit frames; no `frame_err`.
- Short frame: 23 bits of 0xFFFFFF as frame 1 → `frame_err` pulse, `reg_coarseovf` unchanged; the next full frame 0x000042 lands in `reg_coarseovf` (`word_idx`=1).
- Wrap-around: 10 consecutive frames → second pass overwrites all registers; `cfg_done` pulses twice; index returns to 0.
- Reset mid-frame: assert `rst` after 12 bits of frame 2 → all outputs 0 immediately; the next complete frame 0x123456 writes `reg_config`.
- Sampling margin: f_sclk = f_clk/4 with random `clk`/`sclk` phase → all five words received bit-exact.
